// File: rtl/reg_serializer.sv
// Parallel-to-serial transmitter: captures a word on load and streams it out
// one bit per valid/ready transfer, flagging the final bit of each word.
module reg_serializer #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic             ready,
    output logic [WIDTH-1:0] z,
    output logic             busy,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             dropped
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shift_r, shift_s;
    logic [WIDTH-1:0] z_r, z_s;
    logic [CW-1:0]    count_r, count_s;
    logic             dropped_r, dropped_s;
    logic             xfer_s, final_s;

    // Move the word one position toward the serial output end, filling with zero.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            shift_once = {v[WIDTH-2:0], 1'b0};
        end else begin
            shift_once = {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    // Next-state and datapath decode.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        z_s       = z_r;
        count_s   = count_r;
        dropped_s = 1'b0;
        xfer_s    = (state_r == SHIFT) && ready;
        final_s   = xfer_s && (count_r == LAST);
        case (state_r)
            IDLE: begin
                if (load) begin
                    z_s     = d;
                    shift_s = d;
                    count_s = {CW{1'b0}};
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (final_s) begin
                    // A load on the final-bit edge chains the next word with no bubble.
                    if (load) begin
                        z_s     = d;
                        shift_s = d;
                        count_s = {CW{1'b0}};
                        state_s = SHIFT;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (xfer_s) begin
                    shift_s   = shift_once(shift_r);
                    count_s   = count_r + CW'(1);
                    dropped_s = load;
                end else begin
                    dropped_s = load;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            shift_r   <= {WIDTH{1'b0}};
            z_r       <= {WIDTH{1'b0}};
            count_r   <= {CW{1'b0}};
            dropped_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            z_r       <= z_s;
            count_r   <= count_s;
            dropped_r <= dropped_s;
        end
    end

    assign z          = z_r;
    assign busy       = (state_r == SHIFT);
    assign sout_valid = (state_r == SHIFT);
    assign sout       = (state_r == SHIFT) && (MSB_FIRST ? shift_r[WIDTH-1] : shift_r[0]);
    assign sout_last  = (state_r == SHIFT) && (count_r == LAST);
    assign dropped    = dropped_r;

endmodule
